pipeline_hazard_ctrl: RTL and testbench

Front-end hazard and redirect controller for the 5-stage 64-bit pipeline. Drives the PC update, IF/ID capture/flush, and ID/EX and EX/MEM bubble controls from three events: load-use hazards, taken branches resolved at EX/MEM, and instruction-memory fetch stalls. A two-state FSM tracks a branch redirect issued while a fetch is outstanding, so the stale returned word is discarded. Saturating counters expose stall and flush statistics.

---
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side control bundle for the hazard/redirect controller.
// The pipeline uses the master view and the controller uses the slave view.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  imem_valid;
    logic [REG_ADDR_W-1:0] IFID_rs1;
    logic [REG_ADDR_W-1:0] IFID_rs2;
    logic                  IFID_uses_rs2;
    logic                  IDEX_MemRead;
    logic [REG_ADDR_W-1:0] IDEX_rd;
    logic                  EXMEM_branch_taken;
    logic                  PC_write;
    logic                  PC_sel;
    logic                  IFID_write;
    logic                  IFID_flush;
    logic                  IDEX_bubble;
    logic                  EXMEM_flush;
    logic                  drain;

    modport master (
        output imem_valid, IFID_rs1, IFID_rs2, IFID_uses_rs2,
               IDEX_MemRead, IDEX_rd, EXMEM_branch_taken,
        input  PC_write, PC_sel, IFID_write, IFID_flush,
               IDEX_bubble, EXMEM_flush, drain
    );

    modport slave (
        input  imem_valid, IFID_rs1, IFID_rs2, IFID_uses_rs2,
               IDEX_MemRead, IDEX_rd, EXMEM_branch_taken,
        output PC_write, PC_sel, IFID_write, IFID_flush,
               IDEX_bubble, EXMEM_flush, drain
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard and redirect controller: load-use stalls, taken-branch
// redirects, fetch stalls, stale-fetch discard after redirect, and saturating statistics.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t            state_r;
    state_t            state_next_s;
    logic              load_use_s;
    logic              pc_write_s;
    logic              pc_sel_s;
    logic              ifid_write_s;
    logic              ifid_flush_s;
    logic              idex_bubble_s;
    logic              exmem_flush_s;
    logic              drain_s;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  flush_events_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign load_use_s = bus.IDEX_MemRead && (bus.IDEX_rd != ZERO_REG) &&
                        ((bus.IDEX_rd == bus.IFID_rs1) ||
                         (bus.IFID_uses_rs2 && (bus.IDEX_rd == bus.IFID_rs2)));

    // Prioritised control decode and next-state selection
    always_comb begin
        state_next_s  = state_r;
        pc_write_s    = 1'b0;
        pc_sel_s      = 1'b0;
        ifid_write_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        exmem_flush_s = 1'b0;
        drain_s       = (state_r == DRAIN);
        if (reset) begin
            state_next_s  = RUN;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            exmem_flush_s = 1'b1;
            drain_s       = 1'b0;
        end else if (bus.EXMEM_branch_taken) begin
            pc_write_s    = 1'b1;
            pc_sel_s      = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            exmem_flush_s = 1'b1;
            // A redirect during DRAIN still has the old fetch in flight.
            if (state_r == DRAIN) begin
                state_next_s = DRAIN;
            end else if (bus.imem_valid) begin
                state_next_s = RUN;
            end else begin
                state_next_s = DRAIN;
            end
        end else if (state_r == DRAIN) begin
            ifid_flush_s = 1'b1;
            if (bus.imem_valid) begin
                state_next_s = RUN;
            end else begin
                state_next_s = DRAIN;
            end
        end else if (load_use_s) begin
            idex_bubble_s = 1'b1;
        end else if (!bus.imem_valid) begin
            ifid_write_s = 1'b1;
            ifid_flush_s = 1'b1;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating stall and flush statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= '0;
            flush_events_r <= '0;
        end else begin
            if (!pc_write_s) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (bus.EXMEM_branch_taken) begin
                flush_events_r <= sat_inc(flush_events_r);
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign bus.PC_write    = pc_write_s;
    assign bus.PC_sel      = pc_sel_s;
    assign bus.IFID_write  = ifid_write_s;
    assign bus.IFID_flush  = ifid_flush_s;
    assign bus.IDEX_bubble = idex_bubble_s;
    assign bus.EXMEM_flush = exmem_flush_s;
    assign bus.drain       = drain_s;
    assign stall_cycles    = stall_cycles_r;
    assign flush_events    = flush_events_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl, checked against a
// rule-level reference model of the controls and statistics.
module tb_pipeline_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit m_drain = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check the controls, then the post-edge counters.
    task automatic step(input string tag, input bit rst, input bit iv, input bit ld,
                        input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input bit u2, input bit br);
        logic [6:0] e;
        logic [6:0] o;
        bit lu;
        @(negedge clk);
        reset                  = rst;
        bus.imem_valid         = iv;
        bus.IDEX_MemRead       = ld;
        bus.IDEX_rd            = rd;
        bus.IFID_rs1           = rs1;
        bus.IFID_rs2           = rs2;
        bus.IFID_uses_rs2      = u2;
        bus.EXMEM_branch_taken = br;
        #1;
        lu = ld && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
        // {PC_write, PC_sel, IFID_write, IFID_flush, IDEX_bubble, EXMEM_flush, drain}
        if (rst)          e = 7'b0001110;
        else if (br)      e = {6'b110111, m_drain};
        else if (m_drain) e = 7'b0001001;
        else if (lu)      e = 7'b0000100;
        else if (!iv)     e = 7'b0011000;
        else              e = 7'b1010000;
        o = {bus.PC_write, bus.PC_sel, bus.IFID_write, bus.IFID_flush,
             bus.IDEX_bubble, bus.EXMEM_flush, bus.drain};
        check({tag, ":ctl"}, {25'd0, o}, {25'd0, e});
        @(posedge clk);
        if (rst) begin
            m_drain = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e[6] && m_stall < CMAX) m_stall++;
            if (br) begin
                if (m_flush < CMAX) m_flush++;
                if (!m_drain) m_drain = !iv;
            end else if (m_drain && iv) begin
                m_drain = 1'b0;
            end
        end
        #1;
        check({tag, ":stall"}, {26'd0, stall_cycles}, m_stall);
        check({tag, ":flush"}, {26'd0, flush_events}, m_flush);
    endtask

    initial begin
        // reset held two cycles, then normal flow
        step("rst0", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("rst1", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("norm", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("cnt_after_rst", {26'd0, stall_cycles}, 32'd0);

        // load-use on rs1, then register zero never hazards
        step("lu_rs1", 0, 1, 1, 5'd5, 5'd5, 5'd1, 0, 0);
        step("lu_after", 0, 1, 0, 5'd5, 5'd5, 5'd1, 0, 0);
        check("lu_stall_cnt", {26'd0, stall_cycles}, 32'd1);
        step("lu_x0", 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0);

        // rs2 match only counts when the instruction reads rs2
        step("rs2_unused", 0, 1, 1, 5'd7, 5'd3, 5'd7, 0, 0);
        step("rs2_used", 0, 1, 1, 5'd7, 5'd3, 5'd7, 1, 0);
        check("rs2_stall_cnt", {26'd0, stall_cycles}, 32'd2);

        // taken branch with fetch returning: stays in RUN
        step("br_iv1", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        check("br_flush_cnt", {26'd0, flush_events}, 32'd1);
        step("br_iv1_next", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // taken branch with fetch outstanding: three DRAIN cycles
        step("br_iv0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("drain0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("drain1", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("drain_ret", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("drain_stall_cnt", {26'd0, stall_cycles}, 32'd5);
        step("run_after", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // load-use beats fetch stall; branch beats load-use
        step("lu_iv0", 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
        step("lu_br", 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1);

        // branch arriving during DRAIN keeps DRAIN
        step("br2_iv0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("br_in_drain", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("drain_hold", 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0);
        step("run_again", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // reset mid-DRAIN drops the pending discard
        step("br3_iv0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("rst_drain", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("post_rst", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // long fetch stall drives stall_cycles to saturation
        for (int i = 0; i < CMAX + 4; i++)
            step("sat", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("stall_saturated", {26'd0, stall_cycles}, CMAX);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 800; i++) begin
            step("rand",
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
